// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered read data, flags derived from the registered count.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DWIDTH-1:0]       din,
    output logic [DWIDTH-1:0]       dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [DWIDTH-1:0] dout_q,   dout_d;
    logic              wr_acc;
    logic              rd_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: expected data queued on write, compared on read.
// Flag checks compile in when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DWIDTH = 16;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              wr_en;
    logic              rd_en;
    logic [DWIDTH-1:0] din;
    logic [DWIDTH-1:0] dout;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int checks = 0;
    int errors = 0;
    logic [DWIDTH-1:0] sb[$];
    logic [DWIDTH-1:0] exp_d;
    logic [DWIDTH-1:0] last_dout;

    sync_fifo #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rstn  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        for (int i = 0; i < 3; i++) begin
            #6;
            checks++;
            if ({empty, full, count, dout} !== {1'b1, 1'b0, CW'(0), DWIDTH'(0)}) begin
                errors++;
                $display("FAIL reset_hold t=%0t: empty=%b full=%b count=%0d dout=%h, want 1 0 0 0000",
                         $time, empty, full, count, dout);
            end
        end
        #2 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({empty, full, count, dout} !== {1'b1, 1'b0, CW'(0), DWIDTH'(0)}) begin
            errors++;
            $display("FAIL reset_release: empty=%b full=%b count=%0d dout=%h, want 1 0 0 0000",
                     empty, full, count, dout);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b udf=%b, want 0 0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            din   = DWIDTH'(16'h1100 + 16'h0111 * i);
            sb.push_back(din);
            @(negedge clk);
            checks++;
            if (count !== CW'(i + 1) || empty !== 1'b0 || full !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL fill[%0d]: count=%0d empty=%b full=%b, want %0d 0 %b",
                         i, count, empty, full, i + 1, (i == DEPTH - 1));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        rd_en = 1'b0;
        din   = 16'hDEAD;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (count !== CW'(DEPTH) || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_ignored: count=%0d full=%b, want %0d 1", count, full, DEPTH);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %b want 1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
            exp_d = sb.pop_front();
            checks++;
            if (dout !== exp_d || count !== CW'(DEPTH - 1 - i) || empty !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL drain[%0d]: dout=%h count=%0d empty=%b, want %h %0d %b",
                         i, dout, count, empty, exp_d, DEPTH - 1 - i, (i == DEPTH - 1));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        last_dout = dout;
        rd_en = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== last_dout || count !== CW'(0) || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_ignored: dout=%h count=%0d empty=%b, want %h 0 1",
                     dout, count, empty, last_dout);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_flag: got %b want 1", underflow);
        end
`endif
        // Read and write together while empty: write lands, no bypass to dout.
        wr_en = 1'b1;
        din   = 16'h5A5A;
        sb.push_back(din);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (dout !== last_dout || count !== CW'(1) || empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: dout=%h count=%0d empty=%b, want %h 1 0",
                     dout, count, empty, last_dout);
        end
        // Read and write together with one entry: both accepted, count holds.
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'hC3C3;
        sb.push_back(din);
        @(negedge clk);
        wr_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (dout !== exp_d || count !== CW'(1)) begin
            errors++;
            $display("FAIL both_rw: dout=%h count=%0d, want %h 1", dout, count, exp_d);
        end
        @(negedge clk);
        rd_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (dout !== exp_d || count !== CW'(0) || empty !== 1'b1) begin
            errors++;
            $display("FAIL both_rw_tail: dout=%h count=%0d empty=%b, want %h 0 1",
                     dout, count, empty, exp_d);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            din   = DWIDTH'(16'h7000 + i);
            sb.push_back(din);
            @(negedge clk);
        end
        // Full with both requests: read accepted, write ignored.
        rd_en = 1'b1;
        din   = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (dout !== exp_d || count !== CW'(DEPTH - 1) || full !== 1'b0) begin
            errors++;
            $display("FAIL full_rw: dout=%h count=%0d full=%b, want %h %0d 0",
                     dout, count, full, exp_d, DEPTH - 1);
        end
        while (sb.size() > 0) begin
            rd_en = 1'b1;
            @(negedge clk);
            exp_d = sb.pop_front();
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("FAIL full_rw_drain: dout=%h want %h", dout, exp_d);
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== CW'(0)) begin
            errors++;
            $display("FAIL full_rw_empty: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        logic pend = 1'b0;
        fork
            begin
                for (int c = 0; c < 400 && sent < 16; c++) begin
                    @(negedge clk);
                    if (!full && $urandom_range(0, 3) != 0) begin
                        wr_en = 1'b1;
                        din   = DWIDTH'(16'hA000 + 16'h0101 * sent);
                        sb.push_back(din);
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge clk);
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && got < 16; c++) begin
                    @(negedge clk);
                    if (count > CW'(DEPTH)) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_count: count=%0d exceeds %0d", count, DEPTH);
                    end
                    if (pend) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL stream_sb: dout=%h with no expected entry", dout);
                        end else begin
                            exp_d = sb.pop_front();
                            if (dout !== exp_d) begin
                                errors++;
                                $display("FAIL stream_data[%0d]: dout=%h want %h", got, dout, exp_d);
                            end
                        end
                        got++;
                    end
                    pend  = !empty && ($urandom_range(0, 2) != 0);
                    rd_en = pend;
                end
                rd_en = 1'b0;
            end
        join
        checks++;
        if (got != 16 || sent != 16) begin
            errors++;
            $display("FAIL stream_timeout: sent=%0d got=%0d, want 16 16", sent, got);
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || count !== CW'(0)) begin
            errors++;
            $display("FAIL stream_end: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = DWIDTH'(16'h3300 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        // Assert reset between edges to show it acts without a clock edge.
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({empty, full, count, dout} !== {1'b1, 1'b0, CW'(0), DWIDTH'(0)}) begin
            errors++;
            $display("FAIL mid_reset: empty=%b full=%b count=%0d dout=%h, want 1 0 0 0000",
                     empty, full, count, dout);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_flags: ovf=%b udf=%b, want 0 0", overflow, underflow);
        end
`endif
        wr_en = 1'b1;
        din   = 16'h9999;
        sb.delete();
        sb.push_back(din);
        #1 rstn = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (count !== CW'(1) || empty !== 1'b0) begin
            errors++;
            $display("FAIL first_write: count=%0d empty=%b, want 1 0", count, empty);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (dout !== exp_d || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read: dout=%h empty=%b, want %h 1", dout, empty, exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_full_rw();
        test_stream();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
